// File: rtl/bc_stage_if.sv
// Instruction fetch stage.
// Issues word fetches over a req/gnt + rvalid memory port. Responses come back in
// order, land in a small FIFO and go to decode as valid/instr/pc.
//
// Handshakes:
// - Memory request: it transfers on a cycle where o_imem_req && i_imem_gnt.
//   o_imem_addr holds steady while req is high and gnt is low.
// - Memory response: i_imem_rvalid is a one-cycle, in-order return with no backpressure.
// - Decode: an instruction transfers on a cycle where o_instr_valid && !i_stall.
// A redirect kills the FIFO contents and every fetch still in flight.
module bc_stage_if #(
    parameter int                    INSTR_WIDTH = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    FIFO_DEPTH  = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    output logic                   o_imem_req,
    output logic [ADDR_WIDTH-1:0]  o_imem_addr,
    input  logic                   i_imem_gnt,
    input  logic                   i_imem_rvalid,
    input  logic [INSTR_WIDTH-1:0] i_imem_rdata,
    input  logic                   i_redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  i_redirect_pc,
    input  logic                   i_stall,
    output logic                   o_instr_valid,
    output logic [INSTR_WIDTH-1:0] o_instr,
    output logic [ADDR_WIDTH-1:0]  o_pc
);

    // Counters must be able to hold the value FIFO_DEPTH.
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [ADDR_WIDTH-1:0]  fetch_pc;
    logic [ADDR_WIDTH-1:0]  resp_pc;
    logic [CW-1:0]          ocnt;      // fetches granted but not yet answered
    logic [CW-1:0]          dcnt;      // answers still owed that must be dropped
    logic [CW-1:0]          fcnt;      // FIFO occupancy
    logic [PW-1:0]          rd_ptr;
    logic [PW-1:0]          wr_ptr;
    logic [INSTR_WIDTH-1:0] buf_instr [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]  buf_pc    [FIFO_DEPTH];

    logic [CW:0]            inflight;
    logic                   fire;
    logic                   resp_ok;
    logic                   drop;
    logic                   push;
    logic                   pop;
    logic [CW-1:0]          ocnt_next;
    logic [ADDR_WIDTH-1:0]  tgt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Request, response and pop qualification. All of this is combinational from registers and inputs.
    always_comb begin
        inflight    = {1'b0, ocnt} + {1'b0, fcnt};
        // A fetch is requested only when there is a FIFO slot for every fetch in flight.
        o_imem_req  = i_rstn && !i_redirect_valid && (inflight < (CW+1)'(FIFO_DEPTH));
        o_imem_addr = fetch_pc;
        fire        = o_imem_req && i_imem_gnt;
        // A response is ignored when nothing is outstanding.
        resp_ok     = i_imem_rvalid && (ocnt != '0);
        drop        = resp_ok && (dcnt != '0);
        push        = resp_ok && (dcnt == '0) && !i_redirect_valid;
        o_instr_valid = i_rstn && (fcnt != '0) && !i_redirect_valid;
        o_instr     = buf_instr[rd_ptr];
        o_pc        = buf_pc[rd_ptr];
        pop         = o_instr_valid && !i_stall;
        ocnt_next   = ocnt + CW'(fire) - CW'(resp_ok);
        tgt         = {i_redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    end

    // Control state. A redirect overrides push, pop and fire. Every fetch left in
    // flight after the redirect edge is marked to be dropped.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            ocnt     <= '0;
            dcnt     <= '0;
            fcnt     <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            ocnt <= ocnt_next;
            if (i_redirect_valid) begin
                fetch_pc <= tgt;
                resp_pc  <= tgt;
                dcnt     <= ocnt_next;
                fcnt     <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (fire) fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
                if (drop) dcnt <= dcnt - CW'(1);
                if (push) begin
                    resp_pc <= resp_pc + ADDR_WIDTH'(4);
                    wr_ptr  <= ptr_inc(wr_ptr);
                end
                if (pop) rd_ptr <= ptr_inc(rd_ptr);
                fcnt <= fcnt + CW'(push) - CW'(pop);
            end
        end
    end

    // FIFO storage. It has no reset because occupancy is tracked by fcnt.
    always_ff @(posedge i_clk) begin
        if (push) begin
            buf_instr[wr_ptr] <= i_imem_rdata;
            buf_pc[wr_ptr]    <= resp_pc;
        end
    end

    // Memory protocol violation: a response arrived while no fetch was outstanding.
    rvalid_needs_outstanding: assert property (
        @(posedge i_clk) disable iff (!i_rstn) !(i_imem_rvalid && (ocnt == '0))
    );

endmodule

// File: tb/tb_bc_stage_if.sv
// Bench for bc_stage_if: random memory and decode stimulus checked against a transaction-level reference model.
module tb_bc_stage_if;

    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt = 1'b0;
    logic        i_imem_rvalid = 1'b0;
    logic [31:0] i_imem_rdata = '0;
    logic        i_redirect_valid = 1'b0;
    logic [31:0] i_redirect_pc = '0;
    logic        i_stall = 1'b0;
    logic        o_instr_valid;
    logic [31:0] o_instr;
    logic [31:0] o_pc;

    bc_stage_if #(
        .INSTR_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)
    ) dut (
        .i_clk(clk), .i_rstn(rstn),
        .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_gnt(i_imem_gnt),
        .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
        .i_redirect_valid(i_redirect_valid), .i_redirect_pc(i_redirect_pc),
        .i_stall(i_stall), .o_instr_valid(o_instr_valid), .o_instr(o_instr), .o_pc(o_pc)
    );

    // Clock and reset
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          epoch;
        int          ready;
    } txn_t;

    txn_t        pend[$];     // memory: granted fetches awaiting their response
    logic [63:0] exp_q[$];    // scoreboard: {instr, pc} expected at decode, in order
    logic [31:0] model_pc;
    int          epoch = 0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          pops = 0;
    int          gnt_pct = 100, stall_pct = 0, redir_pct = 0, dmax = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    endtask

    // Driver: reset cycles with the model cleared.
    task automatic do_reset(input int n);
        pend.delete();
        exp_q.delete();
        epoch++;
        model_pc = RST_PC;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rstn = 1'b0;
            i_imem_gnt = 1'b0;
            i_imem_rvalid = 1'b0;
            i_redirect_valid = 1'b0;
            i_stall = 1'b0;
            #1;
            check("req_in_reset", o_imem_req, 1'b0);
            check("valid_in_reset", o_instr_valid, 1'b0);
            cyc++;
        end
    endtask

    // Driver: one cycle of memory/decode stimulus and the reference model update.
    task automatic step(input bit force_redir, input logic [31:0] force_pc);
        txn_t r;
        txn_t t;
        bit   resp;
        bit   redir;
        bit   exp_req;
        @(negedge clk);
        rstn = 1'b1;
        redir = force_redir || ($urandom_range(99) < redir_pct);
        i_redirect_valid = redir;
        i_redirect_pc = force_redir ? force_pc : $urandom;
        i_stall = ($urandom_range(99) < stall_pct);
        i_imem_gnt = ($urandom_range(99) < gnt_pct);
        resp = 1'b0;
        if (pend.size() > 0 && pend[0].ready <= cyc) begin
            r = pend.pop_front();
            resp = 1'b1;
        end
        i_imem_rvalid = resp;
        i_imem_rdata = resp ? r.data : $urandom;
        #1;
        // The number of fetches in flight plus buffered instructions may never exceed DEPTH.
        exp_req = !redir && ((pend.size() + int'(resp) + exp_q.size()) < DEPTH);
        check("imem_req", o_imem_req, exp_req);
        if (exp_req) check("imem_addr", o_imem_addr, model_pc);
        check("instr_valid", o_instr_valid, (exp_q.size() > 0) && !redir);
        // Only responses to fetches from the current epoch reach decode.
        if (resp && !redir && r.epoch == epoch) exp_q.push_back({r.data, r.addr});
        if (redir) begin
            exp_q.delete();
            epoch++;
            model_pc = i_redirect_pc & ~32'h3;
        end else if (exp_req && i_imem_gnt) begin
            t.addr = model_pc;
            t.data = $urandom;
            t.epoch = epoch;
            t.ready = cyc + int'($urandom_range(dmax, 1));
            pend.push_back(t);
            model_pc = model_pc + 32'd4;
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0);
    endtask

    // Monitor: compare every instruction handed to decode against the scoreboard.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rstn && o_instr_valid && !i_stall) begin
                pops++;
                if (exp_q.size() == 0) begin
                    check("unexpected_instr_pc", o_pc, 32'hDEAD_BEEF);
                end else begin
                    e = exp_q.pop_front();
                    check("instr", o_instr, e[63:32]);
                    check("pc", o_pc, e[31:0]);
                end
            end
        end
    end

    initial begin
        do_reset(3);
        // Plain streaming from RESET_PC, which wraps to 0.
        gnt_pct = 100; stall_pct = 0; redir_pct = 0; dmax = 1;
        run(20);
        // Decode stall, then release.
        stall_pct = 100; run(6);
        stall_pct = 0;   run(10);
        // Grant withheld, then restored.
        gnt_pct = 0;     run(4);
        gnt_pct = 100;   run(10);
        // Redirect with slow memory so that fetches are in flight.
        dmax = 3;        run(10);
        step(1'b1, 32'h0000_0103);
        run(10);
        // Redirect on a response cycle, then a second redirect on the next cycle.
        for (int i = 0; i < 20; i++) begin
            if (pend.size() > 0 && pend[0].ready <= cyc) begin
                step(1'b1, 32'h0000_0103);
                step(1'b1, 32'h0000_0200);
                break;
            end
            step(1'b0, '0);
        end
        run(10);
        // Random mix.
        gnt_pct = 70; stall_pct = 30; redir_pct = 5; dmax = 3;
        run(400);
        // Reset in the middle of the stream, then fetch from RESET_PC again.
        do_reset(2);
        gnt_pct = 100; stall_pct = 0; redir_pct = 0; dmax = 1;
        run(15);
        // Drain what is left, with a bounded number of cycles.
        gnt_pct = 0;
        for (int i = 0; i < 40 && (pend.size() + exp_q.size()) > 0; i++) step(1'b0, '0);
        check("drained", pend.size() + exp_q.size(), 0);
        check("instr_seen", pops > 50, 1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
